// File: rtl/stream_fifo_pkg.sv
// rtl/stream_fifo_pkg.sv - shared sizing helpers for the watermark stream FIFO
package stream_fifo_pkg;

  localparam int unsigned MaxDepth = 65536;

  function automatic int unsigned usage_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // A single-entry FIFO still needs a one-bit pointer to index its storage.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_fifo_wrap_ptr.sv
// rtl/stream_fifo_wrap_ptr.sv - circular pointer wrapping from Depth-1 to 0 for any depth
module stream_fifo_wrap_ptr
  import stream_fifo_pkg::*;
#(
  parameter int unsigned Depth    = 8,
  parameter int unsigned PtrWidth = ptr_width(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [PtrWidth-1:0] ptr_o
);

  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  logic [PtrWidth-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == LastPtr) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/stream_fifo_watermark.sv
// rtl/stream_fifo_watermark.sv - ready/valid FIFO with exact fill level, watermarks and peak occupancy
module stream_fifo_watermark
  import stream_fifo_pkg::*;
#(
  parameter int unsigned Depth       = 8,
  parameter type         type_t      = logic,
  parameter bit          FallThrough = 1'b0,
  parameter int unsigned UsageWidth  = usage_width(Depth)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  clear_stats_i,
  input  logic [UsageWidth-1:0] afull_thresh_i,
  input  logic [UsageWidth-1:0] aempty_thresh_i,
  input  type_t                 data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output type_t                 data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [UsageWidth-1:0] usage_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [UsageWidth-1:0] max_usage_o
);

  localparam int unsigned           PtrWidth = ptr_width(Depth);
  localparam logic [UsageWidth-1:0] DepthU   = UsageWidth'(Depth);

  if (Depth == 0 || Depth > MaxDepth) begin : g_bad_depth
    $fatal(1, "stream_fifo_watermark: Depth must be within 1..65536");
  end

  type_t                 mem_q [Depth];
  logic [PtrWidth-1:0]   wr_ptr, rd_ptr;
  logic [UsageWidth-1:0] usage_d, usage_q;
  logic [UsageWidth-1:0] max_usage_d, max_usage_q;
  logic                  empty, bypass, push, pop, do_write, do_read;

  assign empty   = (usage_q == '0);
  assign ready_o = (usage_q != DepthU);
  // In fall-through mode an empty FIFO presents the producer directly to the consumer.
  assign bypass  = FallThrough && empty;
  assign valid_o = bypass ? valid_i : !empty;
  assign data_o  = bypass ? data_i : mem_q[rd_ptr];

  assign push     = valid_i & ready_o;
  assign pop      = valid_o & ready_i;
  assign do_write = push & !(bypass & pop) & !flush_i;
  assign do_read  = pop & !bypass & !flush_i;

  always_comb begin
    usage_d = usage_q;
    if (flush_i) begin
      usage_d = '0;
    end else begin
      usage_d = usage_q + UsageWidth'(do_write) - UsageWidth'(do_read);
    end
  end

  always_comb begin
    max_usage_d = max_usage_q;
    if (clear_stats_i) begin
      max_usage_d = usage_d;
    end else if (usage_d > max_usage_q) begin
      max_usage_d = usage_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      usage_q     <= '0;
      max_usage_q <= '0;
    end else begin
      usage_q     <= usage_d;
      max_usage_q <= max_usage_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  stream_fifo_wrap_ptr #(.Depth(Depth), .PtrWidth(PtrWidth)) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .inc_i  (do_write),
    .ptr_o  (wr_ptr)
  );

  stream_fifo_wrap_ptr #(.Depth(Depth), .PtrWidth(PtrWidth)) u_rd_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .inc_i  (do_read),
    .ptr_o  (rd_ptr)
  );

  assign usage_o        = usage_q;
  assign max_usage_o    = max_usage_q;
  assign almost_full_o  = (usage_q >= afull_thresh_i);
  assign almost_empty_o = (usage_q <= aempty_thresh_i);

`ifndef SYNTHESIS
  usage_bound_a : assert property (@(posedge clk_i) disable iff (!rst_ni) usage_q <= DepthU);

  if (!FallThrough) begin : g_stable_chk
    data_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_o && !ready_i) |=> (!valid_o || $stable(data_o)));
  end
`endif

endmodule

// File: tb/tb_stream_fifo_watermark.sv
// tb/tb_stream_fifo_watermark.sv - directed bench over several depths and modes of stream_fifo_watermark
module tb_stream_fifo_watermark;

  typedef logic [7:0] byte_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       clr_stats = 1'b0;
  logic [3:0] af_thr = 4'd0;
  logic [3:0] ae_thr = 4'd0;
  byte_t      din = 8'h00;
  logic       vin = 1'b0;
  logic       rdy_in = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Depth 5, normal
  logic rdy5, vld5, af5, ae5;
  byte_t d5;
  logic [2:0] u5, m5;
  stream_fifo_watermark #(.Depth(5), .type_t(byte_t), .FallThrough(1'b0)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clear_stats_i(clr_stats),
    .afull_thresh_i(af_thr[2:0]), .aempty_thresh_i(ae_thr[2:0]),
    .data_i(din), .valid_i(vin), .ready_o(rdy5), .data_o(d5), .valid_o(vld5), .ready_i(rdy_in),
    .usage_o(u5), .almost_full_o(af5), .almost_empty_o(ae5), .max_usage_o(m5));

  // Depth 3, normal
  logic rdy3, vld3, af3, ae3;
  byte_t d3;
  logic [1:0] u3, m3;
  stream_fifo_watermark #(.Depth(3), .type_t(byte_t), .FallThrough(1'b0)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clear_stats_i(clr_stats),
    .afull_thresh_i(af_thr[1:0]), .aempty_thresh_i(ae_thr[1:0]),
    .data_i(din), .valid_i(vin), .ready_o(rdy3), .data_o(d3), .valid_o(vld3), .ready_i(rdy_in),
    .usage_o(u3), .almost_full_o(af3), .almost_empty_o(ae3), .max_usage_o(m3));

  // Depth 4, fall-through
  logic rdy4, vld4, af4, ae4;
  byte_t d4;
  logic [2:0] u4, m4;
  stream_fifo_watermark #(.Depth(4), .type_t(byte_t), .FallThrough(1'b1)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clear_stats_i(clr_stats),
    .afull_thresh_i(af_thr[2:0]), .aempty_thresh_i(ae_thr[2:0]),
    .data_i(din), .valid_i(vin), .ready_o(rdy4), .data_o(d4), .valid_o(vld4), .ready_i(rdy_in),
    .usage_o(u4), .almost_full_o(af4), .almost_empty_o(ae4), .max_usage_o(m4));

  // Depth 8, normal
  logic rdy8, vld8, af8, ae8;
  byte_t d8;
  logic [3:0] u8, m8;
  stream_fifo_watermark #(.Depth(8), .type_t(byte_t), .FallThrough(1'b0)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clear_stats_i(clr_stats),
    .afull_thresh_i(af_thr), .aempty_thresh_i(ae_thr),
    .data_i(din), .valid_i(vin), .ready_o(rdy8), .data_o(d8), .valid_o(vld8), .ready_i(rdy_in),
    .usage_o(u8), .almost_full_o(af8), .almost_empty_o(ae8), .max_usage_o(m8));

  // Depth 1, normal
  logic rdy1, vld1, af1, ae1;
  byte_t d1;
  logic [0:0] u1, m1;
  stream_fifo_watermark #(.Depth(1), .type_t(byte_t), .FallThrough(1'b0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clear_stats_i(clr_stats),
    .afull_thresh_i(af_thr[0:0]), .aempty_thresh_i(ae_thr[0:0]),
    .data_i(din), .valid_i(vin), .ready_o(rdy1), .data_o(d1), .valid_o(vld1), .ready_i(rdy_in),
    .usage_o(u1), .almost_full_o(af1), .almost_empty_o(ae1), .max_usage_o(m1));

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vin = 1'b0;
    rdy_in = 1'b0;
    flush = 1'b0;
    clr_stats = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int nxt;

    // Depth 5: reset state, fill to full, drain in order
    af_thr = 4'd0;
    ae_thr = 4'd0;
    do_reset();
    check("d5_rst_usage", u5, 0);
    check("d5_rst_valid", vld5, 0);
    check("d5_rst_ready", rdy5, 1);
    check("d5_rst_aempty", ae5, 1);
    check("d5_rst_afull_thr0", af5, 1);
    check("d5_rst_max", m5, 0);
    af_thr = 4'd4;
    for (int i = 0; i < 5; i++) begin
      check("d5_fill_ready", rdy5, 1);
      vin = 1'b1;
      din = byte_t'(8'h0A + i);
      tick();
    end
    vin = 1'b0;
    check("d5_full_ready", rdy5, 0);
    check("d5_full_usage", u5, 5);
    check("d5_full_max", m5, 5);
    check("d5_full_afull", af5, 1);
    rdy_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("d5_drain_valid", vld5, 1);
      check("d5_drain_data", d5, 8'h0A + i);
      tick();
    end
    check("d5_empty_usage", u5, 0);
    check("d5_empty_valid", vld5, 0);
    check("d5_empty_max", m5, 5);

    // Depth 3: fill, then hold valid and ready high; ready_o is low only while full
    do_reset();
    for (int i = 0; i < 3; i++) begin
      vin = 1'b1;
      din = byte_t'(i);
      tick();
    end
    rdy_in = 1'b1;
    nxt = 3;
    for (int k = 0; k < 10; k++) begin
      din = byte_t'(nxt);
      #1;
      check("d3_sus_usage", u3, (k == 0) ? 3 : 2);
      check("d3_sus_ready", rdy3, (k == 0) ? 0 : 1);
      check("d3_sus_data", d3, k);
      tick();
      if (k != 0) nxt++;
    end
    vin = 1'b0;
    rdy_in = 1'b0;

    // Depth 4 fall-through: same-cycle bypass, then a write while consumer stalls
    do_reset();
    vin = 1'b1;
    din = 8'h55;
    rdy_in = 1'b1;
    #1;
    check("d4_ft_valid", vld4, 1);
    check("d4_ft_data", d4, 8'h55);
    check("d4_ft_usage", u4, 0);
    tick();
    check("d4_ft_usage_after", u4, 0);
    check("d4_ft_max_after", m4, 0);
    rdy_in = 1'b0;
    din = 8'h66;
    tick();
    vin = 1'b0;
    #1;
    check("d4_wr_usage", u4, 1);
    check("d4_wr_valid", vld4, 1);
    check("d4_wr_data", d4, 8'h66);

    // Depth 8: watermark thresholds 6 and 1
    af_thr = 4'd6;
    ae_thr = 4'd1;
    do_reset();
    check("d8_rst_afull", af8, 0);
    check("d8_rst_aempty", ae8, 1);
    for (int n = 1; n <= 6; n++) begin
      vin = 1'b1;
      din = byte_t'(n);
      tick();
      check("d8_wm_usage", u8, n);
      check("d8_wm_afull", af8, (n >= 6) ? 1 : 0);
      check("d8_wm_aempty", ae8, (n <= 1) ? 1 : 0);
    end
    vin = 1'b0;
    af_thr = 4'd9;
    #1;
    check("d8_afull_over_depth", af8, 0);

    // Depth 8: flush with a concurrent push, peak survives, then stats clear
    do_reset();
    for (int n = 0; n < 4; n++) begin
      vin = 1'b1;
      din = byte_t'(8'h20 + n);
      tick();
    end
    check("d8_pre_flush_usage", u8, 4);
    flush = 1'b1;
    din = 8'h99;
    tick();
    flush = 1'b0;
    vin = 1'b0;
    check("d8_flush_usage", u8, 0);
    check("d8_flush_valid", vld8, 0);
    check("d8_flush_max", m8, 4);
    check("d8_flush_ready", rdy8, 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("d8_clear_max", m8, 0);

    // Depth 1: fill, then reset mid-stream
    do_reset();
    vin = 1'b1;
    din = 8'h77;
    tick();
    vin = 1'b0;
    check("d1_full_usage", u1, 1);
    check("d1_full_ready", rdy1, 0);
    check("d1_full_valid", vld1, 1);
    check("d1_full_data", d1, 8'h77);
    check("d1_full_max", m1, 1);
    rst_n = 1'b0;
    tick();
    check("d1_rst_usage", u1, 0);
    check("d1_rst_ready", rdy1, 1);
    check("d1_rst_valid", vld1, 0);
    check("d1_rst_max", m1, 0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
